life_step_engine: RTL and testbench

LIFE_STEP_ENGINE -- requirements
Module: life_step_engine

---
 rtl/life_step_engine.sv | 123 ++++++++++++
 tb/tb_life_step_engine.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/life_step_engine.sv
// life_step_engine: streaming Conway B3/S23 next-generation engine over a WORDS x ROWS bit frame
module life_step_engine #(
  parameter int WORDS = 40,
  parameter int ROWS = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frameStart,
  input  logic        inValid,
  output logic        inReady,
  input  logic [15:0] inData,
  output logic        outValid,
  input  logic        outReady,
  output logic [15:0] outData,
  output logic [8:0]  outRow,
  output logic [5:0]  outWord,
  output logic        frameDone
);
  localparam int AW = $clog2(WORDS);
  localparam int CW = $clog2(WORDS + 2);
  localparam logic [CW-1:0] WN = CW'(WORDS);
  localparam logic [CW-1:0] WL = CW'(WORDS - 1);
  localparam logic [CW-1:0] WE = CW'(WORDS + 1);
  localparam logic [8:0] RL = 9'(ROWS - 1);
  typedef enum logic [1:0] {RUN, COL_FLUSH, ROW_FLUSH} state_t;
  state_t state;
  logic arm;
  logic [CW-1:0] w, ow;
  logic [8:0] r, orow;
  logic [15:0] ct, cm, cb, na, nb, nc, nxt;
  logic lt, lm, lb;
  logic [15:0] line_a [WORDS];
  logic [15:0] line_b [WORDS];
  logic [AW-1:0] idx;
  logic [17:0] et, em, eb;
  logic [3:0] n;
  logic adv, fs, acc, flush, tz, lz, ld, sh;
  always_comb begin
    adv = !outValid || outReady;
    fs = frameStart || !arm;
    inReady = arm && state == RUN && adv;
    acc = inReady && inValid && !frameStart;
    idx = w < WN ? w[AW-1:0] : '0;
    na = line_a[idx];
    nb = line_b[idx];
    nc = state == ROW_FLUSH ? 16'h0 : inData;
    flush = state == COL_FLUSH || (state == ROW_FLUSH && w == WN);
    orow = state == ROW_FLUSH ? RL : r - 9'd1;
    ow = flush ? WL : w - CW'(1);
    tz = orow == 9'd0;
    lz = ow == '0;
    et = tz ? '0 : {!flush && na[0], ct, lt && !lz};
    em = {!flush && nb[0], cm, lm && !lz};
    eb = {!flush && nc[0], cb, lb && !lz};
    nxt = '0;
    n = '0;
    for (int i = 0; i < 16; i++) begin
      n = 4'(et[i]) + 4'(et[i+1]) + 4'(et[i+2]) + 4'(em[i]) + 4'(em[i+2]) + 4'(eb[i]) + 4'(eb[i+1]) + 4'(eb[i+2]);
      nxt[i] = n == 4'd3 || (em[i+1] && n == 4'd2);
    end
    ld = !fs && ((state == RUN && acc && r != '0 && w != '0) || (state == COL_FLUSH && adv) ||
                 (state == ROW_FLUSH && adv && w != '0 && w != WE));
    sh = !fs && ((state == RUN && acc) || (state == ROW_FLUSH && adv && w < WN));
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= RUN;
      arm <= 1'b0;
      w <= '0;
      r <= '0;
      {ct, cm, cb, lt, lm, lb} <= '0;
      outValid <= 1'b0;
      outData <= '0;
      outRow <= '0;
      outWord <= '0;
      frameDone <= 1'b0;
    end else begin
      arm <= 1'b1;
      frameDone <= 1'b0;
      if (outValid && outReady) outValid <= 1'b0;
      if (ld) begin
        outValid <= 1'b1;
        outData <= nxt;
        outRow <= orow;
        outWord <= 6'(ow);
      end
      if (sh) begin
        {lt, lm, lb} <= {ct[15], cm[15], cb[15]};
        {ct, cm, cb} <= {na, nb, nc};
      end
      if (fs) begin
        state <= RUN;
        w <= '0;
        r <= '0;
        {ct, cm, cb, lt, lm, lb} <= '0;
        outValid <= 1'b0;
      end else
        case (state)
          RUN: if (acc) begin
            w <= w == WL ? '0 : w + CW'(1);
            if (w == WL && r == '0) r <= 9'd1;
            if (w == WL && r != '0) state <= COL_FLUSH;
          end
          COL_FLUSH: if (adv) begin
            state <= r == RL ? ROW_FLUSH : RUN;
            r <= r == RL ? r : r + 9'd1;
          end
          default: if (w == WE) begin
            if (outValid && outReady) begin
              frameDone <= 1'b1;
              state <= RUN;
              w <= '0;
              r <= '0;
            end
          end else if (adv) w <= w + CW'(1);
        endcase
    end
  always_ff @(posedge clk)
    if (acc) begin
      line_a[idx] <= nb;
      line_b[idx] <= inData;
    end
endmodule

// File: tb/tb_life_step_engine.sv
// tb_life_step_engine: randomized frames checked against a grid-level Game of Life model
module tb_life_step_engine;
  localparam int W = 8, R = 12, PX = W * 16;
  logic clk = 0, rst = 0, frameStart = 0, inValid = 0, outReady = 0;
  logic [15:0] inData = '0;
  logic inReady, outValid, frameDone;
  logic [15:0] outData;
  logic [8:0] outRow;
  logic [5:0] outWord;
  life_step_engine #(.WORDS(W), .ROWS(R)) dut (
    .clk(clk), .rst(rst), .frameStart(frameStart), .inValid(inValid), .inReady(inReady),
    .inData(inData), .outValid(outValid), .outReady(outReady), .outData(outData),
    .outRow(outRow), .outWord(outWord), .frameDone(frameDone)
  );
  always #5 clk = ~clk;
  int compared = 0, mismatched = 0;
  int stall_pct = 0, fd_cnt = 0, stab_err = 0, timeouts = 0, first_bad = -1;
  bit cur [R][PX];
  logic [15:0] exp_w [R][W];
  logic [8:0] q_row [$];
  logic [5:0] q_word [$];
  logic [15:0] q_data [$];
  logic pv = 0, pr = 0;
  logic [15:0] pd = '0;
  logic [8:0] prow = '0;
  logic [5:0] pw = '0;
  initial forever begin
    @(posedge clk);
    #1 outReady = $urandom_range(99) >= stall_pct;
  end
  always @(negedge clk) begin
    if (pv && !pr && (outValid !== 1'b1 || outData !== pd || outRow !== prow || outWord !== pw)) stab_err++;
    if (outValid === 1'b1 && outReady === 1'b1) begin
      q_row.push_back(outRow);
      q_word.push_back(outWord);
      q_data.push_back(outData);
    end
    if (frameDone === 1'b1) fd_cnt++;
    pv = outValid === 1'b1;
    pr = outReady;
    pd = outData;
    prow = outRow;
    pw = outWord;
  end
  function automatic void build_exp();
    for (int r = 0; r < R; r++)
      for (int c = 0; c < PX; c++) begin
        int n = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < R && c + dc >= 0 && c + dc < PX)
              n += int'(cur[r+dr][c+dc]);
        exp_w[r][c/16][c%16] = (n == 3) || (cur[r][c] && n == 2);
      end
  endfunction
  function automatic logic [15:0] word_of(input int r, input int w);
    logic [15:0] v;
    for (int i = 0; i < 16; i++) v[i] = cur[r][w*16+i];
    return v;
  endfunction
  function automatic logic [15:0] got(input int r, input int w);
    int k = r * W + w;
    return k < q_data.size() ? q_data[k] : 16'hxxxx;
  endfunction
  function automatic int score();
    int bad = 0;
    first_bad = -1;
    for (int k = 0; k < q_data.size(); k++)
      if (k >= R * W || int'(q_row[k]) != k / W || int'(q_word[k]) != k % W || q_data[k] !== exp_w[k/W][k%W]) begin
        bad++;
        if (first_bad < 0) first_bad = k;
      end
    return bad;
  endfunction
  task automatic fill_grid(input int pct);
    for (int r = 0; r < R; r++)
      for (int c = 0; c < PX; c++) cur[r][c] = $urandom_range(99) < pct;
  endtask
  task automatic clear_mon();
    q_row.delete();
    q_word.delete();
    q_data.delete();
    fd_cnt = 0;
    stab_err = 0;
    timeouts = 0;
  endtask
  task automatic send_words(input int nw, input int gap);
    int k = 0, cyc = 0;
    logic a;
    while (k < nw && cyc < 20000) begin
      inValid = $urandom_range(99) >= gap;
      inData = word_of(k / W, k % W);
      @(negedge clk);
      a = inValid && inReady;
      @(posedge clk);
      #1;
      if (a) k++;
      cyc++;
    end
    inValid = 1'b0;
    if (k < nw) timeouts++;
  endtask
  task automatic wait_done();
    int cyc = 0;
    while (fd_cnt == 0 && cyc < 5000) begin
      @(posedge clk);
      cyc++;
    end
    if (fd_cnt == 0) timeouts++;
    repeat (20) @(posedge clk);
    #1;
  endtask
  task automatic run_frame(input int gap, input int stall);
    clear_mon();
    build_exp();
    stall_pct = stall;
    send_words(R * W, gap);
    wait_done();
    stall_pct = 0;
  endtask
  task automatic test_reset();
    rst = 0;
    inValid = 1;
    repeat (3) @(posedge clk);
    #1;
    compared++; if (inReady !== 1'b0) begin mismatched++; $display("FAIL reset_inReady got %b need 0", inReady); end
    compared++; if (outValid !== 1'b0) begin mismatched++; $display("FAIL reset_outValid got %b need 0", outValid); end
    compared++; if (outData !== 16'h0) begin mismatched++; $display("FAIL reset_outData got %h need 0000", outData); end
    compared++; if (outRow !== 9'h0) begin mismatched++; $display("FAIL reset_outRow got %0d need 0", outRow); end
    compared++; if (outWord !== 6'h0) begin mismatched++; $display("FAIL reset_outWord got %0d need 0", outWord); end
    compared++; if (frameDone !== 1'b0) begin mismatched++; $display("FAIL reset_frameDone got %b need 0", frameDone); end
    @(negedge clk) rst = 1;
    #1;
    compared++; if (inReady !== 1'b0) begin mismatched++; $display("FAIL reset_release_inReady got %b need 0", inReady); end
    @(posedge clk);
    #1 inValid = 0;
    compared++; if (inReady !== 1'b1) begin mismatched++; $display("FAIL reset_first_edge_inReady got %b need 1", inReady); end
  endtask
  task automatic test_blinker();
    int bad;
    fill_grid(0);
    cur[5][100] = 1; cur[6][100] = 1; cur[7][100] = 1;
    run_frame(0, 0);
    compared++; if (q_data.size() != R * W) begin mismatched++; $display("FAIL blinker_count got %0d need %0d", q_data.size(), R * W); end
    bad = score();
    compared++; if (bad != 0) begin mismatched++; $display("FAIL blinker_words got %0d bad (first %0d) need 0", bad, first_bad); end
    compared++; if (got(6, 6) !== 16'h0038) begin mismatched++; $display("FAIL blinker_line got %h need 0038", got(6, 6)); end
    compared++; if (fd_cnt != 1) begin mismatched++; $display("FAIL blinker_frameDone got %0d need 1", fd_cnt); end
    compared++; if (timeouts != 0) begin mismatched++; $display("FAIL blinker_timeout got %0d need 0", timeouts); end
  endtask
  task automatic test_glider();
    int bad;
    fill_grid(0);
    cur[2][95] = 1; cur[3][96] = 1; cur[4][94] = 1; cur[4][95] = 1; cur[4][96] = 1;
    run_frame(10, 0);
    compared++; if (q_data.size() != R * W) begin mismatched++; $display("FAIL glider_count got %0d need %0d", q_data.size(), R * W); end
    bad = score();
    compared++; if (bad != 0) begin mismatched++; $display("FAIL glider_words got %0d bad (first %0d) need 0", bad, first_bad); end
    compared++; if (got(3, 6) !== 16'h0001) begin mismatched++; $display("FAIL glider_boundary got %h need 0001", got(3, 6)); end
    compared++; if (fd_cnt != 1 || timeouts != 0) begin mismatched++; $display("FAIL glider_done got %0d/%0d need 1/0", fd_cnt, timeouts); end
  endtask
  task automatic test_edges();
    int bad;
    fill_grid(0);
    cur[0][0] = 1; cur[0][1] = 1; cur[1][0] = 1; cur[1][1] = 1;
    run_frame(0, 0);
    bad = score();
    compared++; if (bad != 0 || q_data.size() != R * W) begin mismatched++; $display("FAIL block_words got %0d bad of %0d need 0 of %0d", bad, q_data.size(), R * W); end
    compared++; if (got(0, 0) !== 16'h0003 || got(1, 0) !== 16'h0003) begin mismatched++; $display("FAIL block_corner got %h/%h need 0003/0003", got(0, 0), got(1, 0)); end
    fill_grid(100);
    run_frame(0, 0);
    bad = score();
    compared++; if (bad != 0 || q_data.size() != R * W) begin mismatched++; $display("FAIL ones_words got %0d bad of %0d need 0 of %0d", bad, q_data.size(), R * W); end
    compared++; if (got(0, 0) !== 16'h0001) begin mismatched++; $display("FAIL ones_top_left got %h need 0001", got(0, 0)); end
    compared++; if (got(R - 1, W - 1) !== 16'h8000) begin mismatched++; $display("FAIL ones_bottom_right got %h need 8000", got(R - 1, W - 1)); end
    compared++; if (got(0, 3) !== 16'h0000 || got(5, 3) !== 16'h0000) begin mismatched++; $display("FAIL ones_edge_interior got %h/%h need 0000/0000", got(0, 3), got(5, 3)); end
    compared++; if (fd_cnt != 1 || timeouts != 0) begin mismatched++; $display("FAIL edges_done got %0d/%0d need 1/0", fd_cnt, timeouts); end
  endtask
  task automatic test_backpressure();
    int bad;
    fill_grid(35);
    run_frame(30, 50);
    compared++; if (q_data.size() != R * W) begin mismatched++; $display("FAIL bp_count got %0d need %0d", q_data.size(), R * W); end
    bad = score();
    compared++; if (bad != 0) begin mismatched++; $display("FAIL bp_words got %0d bad (first %0d) need 0", bad, first_bad); end
    compared++; if (stab_err != 0) begin mismatched++; $display("FAIL bp_stable got %0d changes need 0", stab_err); end
    compared++; if (fd_cnt != 1 || timeouts != 0) begin mismatched++; $display("FAIL bp_done got %0d/%0d need 1/0", fd_cnt, timeouts); end
  endtask
  task automatic test_abort();
    int bad;
    fill_grid(100);
    clear_mon();
    stall_pct = 30;
    send_words((R / 2) * W + 3, 20);
    frameStart = 1;
    inValid = 1;
    inData = 16'hffff;
    @(posedge clk);
    #1;
    frameStart = 0;
    inValid = 0;
    repeat (30) @(posedge clk);
    #1;
    compared++; if (fd_cnt != 0 || timeouts != 0) begin mismatched++; $display("FAIL abort_no_done got %0d/%0d need 0/0", fd_cnt, timeouts); end
    fill_grid(30);
    run_frame(20, 30);
    compared++; if (q_data.size() != R * W) begin mismatched++; $display("FAIL abort_count got %0d need %0d", q_data.size(), R * W); end
    bad = score();
    compared++; if (bad != 0) begin mismatched++; $display("FAIL abort_words got %0d bad (first %0d) need 0", bad, first_bad); end
    compared++; if (fd_cnt != 1 || timeouts != 0) begin mismatched++; $display("FAIL abort_done got %0d/%0d need 1/0", fd_cnt, timeouts); end
  endtask
  task automatic test_reset_mid();
    int bad, cyc = 0;
    fill_grid(100);
    clear_mon();
    stall_pct = 50;
    send_words(R * W, 0);
    while (!(outValid === 1'b1 && outRow == 9'(R - 1)) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    compared++; if (cyc >= 2000 || timeouts != 0) begin mismatched++; $display("FAIL rstmid_reach got %0d cycles need <2000", cyc); end
    #2 rst = 0;
    #1;
    compared++; if (outValid !== 1'b0) begin mismatched++; $display("FAIL rstmid_outValid got %b need 0", outValid); end
    compared++; if (inReady !== 1'b0) begin mismatched++; $display("FAIL rstmid_inReady got %b need 0", inReady); end
    repeat (2) @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
    fill_grid(40);
    run_frame(10, 50);
    compared++; if (q_data.size() != R * W) begin mismatched++; $display("FAIL rstmid_count got %0d need %0d", q_data.size(), R * W); end
    bad = score();
    compared++; if (bad != 0) begin mismatched++; $display("FAIL rstmid_words got %0d bad (first %0d) need 0", bad, first_bad); end
    compared++; if (fd_cnt != 1 || timeouts != 0) begin mismatched++; $display("FAIL rstmid_done got %0d/%0d need 1/0", fd_cnt, timeouts); end
  endtask
  initial begin
    test_reset();
    test_blinker();
    test_glider();
    test_edges();
    test_backpressure();
    test_abort();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL global_timeout got running need finished");
    $fatal(1, "time limit");
  end
endmodule
